// File: rtl/y_conv_pkg.sv
// y_conv_pkg: shared types and default sizing for the y-direction
// convolution path (bit selector and accumulator).
//   Y_NUM_TERMS : products per 3x2 Sobel window, shared with the bit selector
//   Y_*_W       : default operand / accumulator / magnitude widths
//   Y_TIMEOUT   : ACCUM cycles tolerated without calc_done
//   y_state_e   : accumulator FSM states
package y_conv_pkg;

  localparam int Y_A_W       = 5;
  localparam int Y_B_W       = 5;
  localparam int Y_NUM_TERMS = 6;
  localparam int Y_ACC_W     = 12;
  localparam int Y_MAG_W     = 8;
  localparam int Y_TIMEOUT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } y_state_e;

endpackage

// File: rtl/y_mac_term.sv
// y_mac_term: one combinational multiply term of the convolution.
//   a    : two's-complement filter coefficient (A_W bits)
//   b    : pixel value, zero-extended (B_W bits)
//   term : signed product a*b, sign-extended to ACC_W bits
// Shared with the x-direction accumulator.
module y_mac_term
  import y_conv_pkg::*;
#(
  parameter int A_W   = Y_A_W,
  parameter int B_W   = Y_B_W,
  parameter int ACC_W = Y_ACC_W
) (
  input  logic        [A_W-1:0]   a,
  input  logic        [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] term
);

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;

  // Extend both operands to the accumulator width first; the product of the
  // extended operands is exact because |a*b| fits in ACC_W bits.
  assign a_ext = ACC_W'($signed(a));
  assign b_ext = ACC_W'($signed({1'b0, b}));
  assign term  = a_ext * b_ext;

endmodule

// File: rtl/y_conv_accumulator.sv
// y_conv_accumulator: accumulates the Gy sum of one window from the bit
// selector's (a, b) stream and hands it downstream with valid/ready.
//   clk, n_rst      : clock, synchronous active-high reset
//   calc_enable     : window start (also starts the bit selector)
//   a, b            : coefficient / pixel pair for this cycle
//   calc_done       : end-of-window pulse, carries no product
//   result          : signed window sum (registered)
//   magnitude       : |result| clipped to 2^MAG_W-1 (registered)
//   result_valid    : result/magnitude/count_err valid
//   result_ready    : downstream accept
//   busy            : window in progress
//   count_err       : term count was not NUM_TERMS, or the window timed out
//   overrun         : one-cycle pulse, a start was dropped while a result waited
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for calc_enable
// ST_ACCUM  | summing one product per cycle until calc_done or timeout
// ST_RESULT | holding result until result_ready; may chain the next start
module y_conv_accumulator
  import y_conv_pkg::*;
#(
  parameter int A_W       = Y_A_W,
  parameter int B_W       = Y_B_W,
  parameter int NUM_TERMS = Y_NUM_TERMS,
  parameter int ACC_W     = Y_ACC_W,
  parameter int MAG_W     = Y_MAG_W,
  parameter int TIMEOUT   = Y_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    calc_enable,
  input  logic        [A_W-1:0]   a,
  input  logic        [B_W-1:0]   b,
  input  logic                    calc_done,
  output logic signed [ACC_W-1:0] result,
  output logic        [MAG_W-1:0] magnitude,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    count_err,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ACC_W:0] MAG_MAX = (ACC_W+1)'((1 << MAG_W) - 1);

  y_state_e                state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt, term;
  logic        [CNT_W-1:0] term_cnt, cnt_nxt;
  logic                    load, err_nxt, overrun_nxt;
  logic        [ACC_W:0]   abs_acc;
  logic        [MAG_W-1:0] mag_sat;

  y_mac_term #(
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .a    (a),
    .b    (b),
    .term (term)
  );

  // One extra bit so that |-2^(ACC_W-1)| is representable before clipping.
  always_comb begin
    abs_acc = {1'b0, acc};
    if (acc[ACC_W-1]) begin
      abs_acc = (~{1'b1, acc}) + (ACC_W+1)'(1);
    end
    mag_sat = (abs_acc > MAG_MAX) ? '1 : abs_acc[MAG_W-1:0];
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = term_cnt;
    load        = 1'b0;
    err_nxt     = count_err;
    overrun_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (calc_enable) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (calc_done) begin
          load      = 1'b1;
          err_nxt   = (term_cnt != CNT_W'(NUM_TERMS));
          state_nxt = ST_RESULT;
        end else if (term_cnt == CNT_W'(TIMEOUT)) begin
          // Terminal count: the bit selector stalled; report what we have.
          load      = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ST_RESULT;
        end else begin
          acc_nxt = acc + term;
          if (term_cnt != '1) begin
            cnt_nxt = term_cnt + CNT_W'(1);
          end
        end
      end
      ST_RESULT: begin
        if (result_ready) begin
          if (calc_enable) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_ACCUM;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (calc_enable) begin
          overrun_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      result    <= '0;
      magnitude <= '0;
      count_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      term_cnt <= cnt_nxt;
      overrun  <= overrun_nxt;
      if (load) begin
        result    <= acc;
        magnitude <= mag_sat;
        count_err <= err_nxt;
      end
    end
  end

  assign busy         = (state == ST_ACCUM);
  assign result_valid = (state == ST_RESULT);

endmodule

// File: tb/tb_y_conv_accumulator.sv
// Testbench for y_conv_accumulator: table of fixed windows, hand-written
// backpressure / reset / stray-control sequences, and random windows checked
// against a plain-arithmetic window model.
module tb_y_conv_accumulator;

  localparam int NT = 6;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               calc_enable;
  logic [4:0]         a;
  logic [4:0]         b;
  logic               calc_done;
  logic signed [11:0] result;
  logic [7:0]         magnitude;
  logic               result_valid;
  logic               result_ready;
  logic               busy;
  logic               count_err;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int va[10];
  int vb[10];
  int lat;

  typedef struct packed {
    int              n;
    bit              wd;
    logic [9:0][4:0] av;
    logic [9:0][4:0] bv;
    int              exp_res;
    int              exp_mag;
    bit              exp_err;
    int              exp_lat;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  y_conv_accumulator dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .calc_enable  (calc_enable),
    .a            (a),
    .b            (b),
    .calc_done    (calc_done),
    .result       (result),
    .magnitude    (magnitude),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .count_err    (count_err),
    .overrun      (overrun)
  );

  function automatic logic [9:0][4:0] pk(input int e0, e1, e2, e3, e4,
                                         e5, e6, e7, e8, e9);
    logic [9:0][4:0] r;
    r[0] = e0[4:0]; r[1] = e1[4:0]; r[2] = e2[4:0]; r[3] = e3[4:0];
    r[4] = e4[4:0]; r[5] = e5[4:0]; r[6] = e6[4:0]; r[7] = e7[4:0];
    r[8] = e8[4:0]; r[9] = e9[4:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Window model: straight from the rules, summing the driven products.
  task automatic model(input int n, input bit wd, output int er, output int em,
                       output bit ee, output int el);
    bit normal;
    int terms;
    int sa;
    normal = wd && (n <= TO);
    terms  = normal ? n : TO;
    er = 0;
    for (int k = 0; k < terms; k++) begin
      if (k < n) begin
        sa = (va[k] >= 16) ? va[k] - 32 : va[k];
        er += sa * vb[k];
      end
    end
    em = (er < 0) ? -er : er;
    if (em > 255) em = 255;
    ee = !normal || (n != NT);
    el = normal ? n + 1 : TO + 1;
  endtask

  // Drive one window: optional start pulse, n products, optional calc_done,
  // then zeros until result_valid (bounded). en_mode: 0 none, 1 random, 2 held
  // calc_enable during ACCUM.
  task automatic run_window(input bit do_en, input int n, input bit wd,
                            input int en_mode);
    bit got;
    if (do_en) begin
      calc_enable = 1'b1; calc_done = 1'b0; a = '0; b = '0;
      tick();
    end
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      calc_done = 1'b0; a = '0; b = '0;
      if (k < n) begin
        a = 5'(va[k]);
        b = 5'(vb[k]);
      end else if (k == n && wd) begin
        calc_done = 1'b1;
      end
      calc_enable = (en_mode == 2) ? 1'b1 :
                    (en_mode == 1) ? 1'($urandom % 2) : 1'b0;
      tick();
      lat++;
      if (result_valid) got = 1'b1;
    end
    calc_enable = 1'b0; calc_done = 1'b0; a = '0; b = '0;
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL valid_timeout actual=no_valid required=valid @%0t", $time);
    end
  endtask

  task automatic verify(input string tag, input int er, input int em,
                        input bit ee, input int el);
    check({tag, ".result"}, int'(result), er);
    check({tag, ".magnitude"}, int'(magnitude), em);
    check({tag, ".count_err"}, int'(count_err), int'(ee));
    check({tag, ".latency"}, lat, el);
    check({tag, ".busy"}, int'(busy), 0);
  endtask

  task automatic handshake(input string tag, input int hold, input int er);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      tick();
      check({tag, ".hold_result"}, int'(result), er);
      check({tag, ".hold_valid"}, int'(result_valid), 1);
    end
    result_ready = 1'b1;
    tick();
    check({tag, ".valid_drop"}, int'(result_valid), 0);
    result_ready = 1'b0;
  endtask

  initial begin
    int er, em, el;
    bit ee;

    tbl[0] = '{6, 1'b1, pk(-1,-2,-1,1,2,1,0,0,0,0), pk(10,10,10,3,3,3,0,0,0,0),
               -28, 28, 1'b0, 7};
    tbl[1] = '{6, 1'b1, pk(-16,-16,-16,-16,-16,-16,0,0,0,0),
               pk(15,15,15,15,15,15,0,0,0,0), -1440, 255, 1'b0, 7};
    tbl[2] = '{6, 1'b1, pk(15,15,15,15,15,15,0,0,0,0),
               pk(15,15,15,15,15,15,0,0,0,0), 1350, 255, 1'b0, 7};
    tbl[3] = '{4, 1'b1, pk(1,2,3,4,0,0,0,0,0,0), pk(5,5,5,5,0,0,0,0,0,0),
               50, 50, 1'b1, 5};
    tbl[4] = '{10, 1'b0, pk(1,1,1,1,1,1,1,1,1,1), pk(1,1,1,1,1,1,1,1,1,1),
               8, 8, 1'b1, 9};
    tbl[5] = '{0, 1'b1, pk(0,0,0,0,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,0,0,0),
               0, 0, 1'b1, 1};
    tbl[6] = '{7, 1'b1, pk(2,2,2,2,2,2,2,0,0,0), pk(3,3,3,3,3,3,3,0,0,0),
               42, 42, 1'b1, 8};
    tbl[7] = '{6, 1'b1, pk(-5,-5,-5,-5,-5,-5,0,0,0,0),
               pk(7,7,7,7,7,7,0,0,0,0), -210, 210, 1'b0, 7};
    tbl[8] = '{6, 1'b1, pk(3,3,3,3,3,3,0,0,0,0),
               pk(14,14,14,14,14,14,0,0,0,0), 252, 252, 1'b0, 7};
    tbl[9] = '{6, 1'b1, pk(-16,-16,0,0,0,0,0,0,0,0), pk(8,8,0,0,0,0,0,0,0,0),
               -256, 255, 1'b0, 7};

    n_rst = 1'b1; calc_enable = 1'b0; a = '0; b = '0; calc_done = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    check("rst.result", int'(result), 0);
    check("rst.magnitude", int'(magnitude), 0);
    check("rst.valid", int'(result_valid), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.count_err", int'(count_err), 0);
    check("rst.overrun", int'(overrun), 0);
    n_rst = 1'b0;
    tick();

    // Fixed windows
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 10; k++) begin
        va[k] = int'(tbl[i].av[k]);
        vb[k] = int'(tbl[i].bv[k]);
      end
      run_window(1'b1, tbl[i].n, tbl[i].wd, 0);
      verify($sformatf("tbl%0d", i), tbl[i].exp_res, tbl[i].exp_mag,
             tbl[i].exp_err, tbl[i].exp_lat);
      handshake($sformatf("tbl%0d", i), 0, tbl[i].exp_res);
    end

    // Backpressure with a dropped start, then zero-gap chained start
    for (int k = 0; k < 10; k++) begin
      va[k] = int'(tbl[0].av[k]);
      vb[k] = int'(tbl[0].bv[k]);
    end
    run_window(1'b1, 6, 1'b1, 0);
    verify("bp", -28, 28, 1'b0, 7);
    for (int h = 0; h < 5; h++) begin
      result_ready = 1'b0;
      calc_enable  = (h == 2);
      tick();
      check("bp.hold_result", int'(result), -28);
      check("bp.hold_valid", int'(result_valid), 1);
      check("bp.hold_busy", int'(busy), 0);
      check("bp.overrun", int'(overrun), (h == 2) ? 1 : 0);
    end
    result_ready = 1'b1; calc_enable = 1'b1;
    tick();
    check("b2b.valid", int'(result_valid), 0);
    check("b2b.busy", int'(busy), 1);
    result_ready = 1'b0; calc_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      va[k] = 15;
      vb[k] = 15;
    end
    run_window(1'b0, 6, 1'b1, 0);
    verify("b2b", 1350, 255, 1'b0, 7);
    handshake("b2b", 1, 1350);

    // Reset mid-window discards the partial sum
    calc_enable = 1'b1;
    tick();
    calc_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 5'd7; b = 5'd15;
      tick();
    end
    a = '0; b = '0;
    n_rst = 1'b1;
    tick();
    check("mid_rst.busy", int'(busy), 0);
    check("mid_rst.result", int'(result), 0);
    check("mid_rst.magnitude", int'(magnitude), 0);
    check("mid_rst.valid", int'(result_valid), 0);
    check("mid_rst.count_err", int'(count_err), 0);
    n_rst = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      va[k] = int'(tbl[0].av[k]);
      vb[k] = int'(tbl[0].bv[k]);
    end
    run_window(1'b1, 6, 1'b1, 0);
    verify("post_rst", -28, 28, 1'b0, 7);
    handshake("post_rst", 0, -28);

    // Stray calc_done in IDLE, calc_enable held through ACCUM
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    check("stray_done.busy", int'(busy), 0);
    check("stray_done.valid", int'(result_valid), 0);
    run_window(1'b1, 6, 1'b1, 2);
    verify("en_in_accum", -28, 28, 1'b0, 7);
    handshake("en_in_accum", 2, -28);

    // Random windows against the model
    for (int r = 0; r < 40; r++) begin
      int n;
      bit wd;
      n  = $urandom_range(0, 10);
      wd = ($urandom % 4) != 0;
      for (int k = 0; k < 10; k++) begin
        va[k] = $urandom_range(0, 31);
        vb[k] = $urandom_range(0, 15);
      end
      model(n, wd, er, em, ee, el);
      run_window(1'b1, n, wd, 1);
      verify($sformatf("rnd%0d", r), er, em, ee, el);
      handshake($sformatf("rnd%0d", r), $urandom_range(0, 3), er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
